rz_decode: RTL and testbench
============================

RZ_DECODE -- requirements
Module: rz_decode

Interface
REQ-001 Parameter T_MIN_HIGH, 8: minimum high width in clk cycles; shorter pulses are glitches.
REQ-002 Parameter T_THRESH, 28: high widths below this decode as 0; widths at or above it decode as 1 (0.56 us at 50 MHz).
REQ-003 Parameter T_MAX_HIGH, 50: maximum legal high width; longer pulses are errors.
REQ-004 Parameter T_RESET, 2500: low width that marks a frame gap (50 us at 50 MHz).
REQ-005 clk  input  1  system clock; all logic rises on posedge clk.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rz_in  input  1  asynchronous WS2812 single-wire RZ line.
REQ-008 rgb  output  24  last complete word, GRB order, first received bit in bit 23.
REQ-009 rgb_valid  output  1  one-cycle pulse when rgb has been updated.
REQ-010 frame_end  output  1  one-cycle pulse when a low gap reaches T_RESET.
REQ-011 bit_err  output  1  one-cycle pulse on any framing violation.
REQ-012 err_cnt  output  16  saturating error count; see Configuration.

Function
REQ-013 rz_in shall pass through a 2-flop synchronizer; edges are detected on the synchronized signal, giving 2 cycles of fixed input latency.
REQ-014 FSM states: SYNC (wait for gap), LOW (measuring low), HIGH (measuring high).
REQ-015 After reset the FSM is in SYNC; it leaves only when the low width reaches T_RESET, then enters LOW with bit_cnt=0. No bits are accepted in SYNC.
REQ-016 LOW -> HIGH on a rising edge; the high-width counter clears to 1.
REQ-017 HIGH -> LOW on a falling edge; the bit is decoded from the high width w:
- w < T_MIN_HIGH: bit_err, go to SYNC.
- T_MIN_HIGH <= w < T_THRESH: shift in 0.
- T_THRESH <= w <= T_MAX_HIGH: shift in 1.
REQ-018 If the high-width counter exceeds T_MAX_HIGH while in HIGH: bit_err, then SYNC (waits for a fresh gap).
REQ-019 Bits shift in MSB first; on the 24th bit, rgb loads and rgb_valid pulses on the cycle after the falling-edge detect (3 cycles after the rz_in pin edge); bit_cnt wraps to 0.
REQ-020 In LOW, when the low-width counter reaches T_RESET: frame_end pulses once per gap. If bit_cnt != 0, bit_err pulses in the same cycle and the partial word is discarded; bit_cnt clears.
REQ-021 Counters saturate at T_RESET; counter width is $clog2(T_RESET+1).
REQ-022 rgb holds its value between updates; a partial word never reaches rgb.
REQ-023 rgb_valid and frame_end cannot coincide, since a rising edge is needed between them.

Reset
REQ-024 On rst: rgb=0, rgb_valid=0, frame_end=0, bit_err=0, err_cnt=0, all counters and the shift register clear, synchronizer flops=0, FSM=SYNC.
REQ-025 Reset asserted mid-word discards the partial word; after release the block requires a full T_RESET gap again.

Configuration
REQ-026 With macro RZ_DECODE_ERRCNT_EN defined, err_cnt increments on each bit_err pulse and saturates at 16'hFFFF.
REQ-027 Without RZ_DECODE_ERRCNT_EN, err_cnt is tied to 0, no counter logic is built, and all other behaviour is identical.

Structure
REQ-028 Shared package rz_pkg holds the WS2812 timing constants (T0H, T1H, T_RESET cycle counts at 50 MHz) and the 24-bit GRB word typedef; the encoder uses the same package.
REQ-029 Sub-module rz_sync holds the 2-flop synchronizer plus rise/fall edge detect; rz_decode instantiates it once.

Verification
REQ-030 Idle low for 2500 cycles, then 24 bits of pattern 0xA5C3F0 (0-bit: 18 high/44 low; 1-bit: 35 high/27 low) -> exactly one rgb_valid, rgb=0xA5C3F0, bit_err=0.
REQ-031 Bits sent after reset without a preceding 2500-cycle low -> no rgb_valid; after a gap, the next word decodes correctly.
REQ-032 12 bits, then low for 2500 cycles -> frame_end and bit_err in the same cycle, rgb unchanged, err_cnt=1 with the macro defined.
REQ-033 A 5-cycle high glitch mid-word -> bit_err; a 60-cycle high -> bit_err at cycle 51 of the high; both recover after a gap.
REQ-034 Two back-to-back words 0x000000 and 0xFFFFFF with no gap -> two rgb_valid pulses, with values in that order.
REQ-035 Loopback from the team's RZ encoder driving a 3-pixel frame -> three rgb_valid pulses matching the encoder's RGB inputs (GRB-mapped), then one frame_end.

Source files
------------

// File: rtl/rz_pkg.sv
// rz_pkg: shared WS2812 timing constants (50 MHz clk) and GRB word types
package rz_pkg;
  localparam int RZ_T0H     = 18;
  localparam int RZ_T1H     = 35;
  localparam int RZ_T0L     = 44;
  localparam int RZ_T1L     = 27;
  localparam int RZ_T_RESET = 2500;
  typedef logic [23:0] grb_t;
  typedef enum logic [1:0] {ST_SYNC, ST_LOW, ST_HIGH} rz_state_t;
  // maps an RGB pixel onto the wire order, first transmitted bit in bit 23
  function automatic grb_t grb_pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return {g, r, b};
  endfunction
endpackage

// File: rtl/rz_sync.sv
// rz_sync: 2-flop synchronizer with rise/fall detect on the synchronized level
module rz_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [1:0] meta;
  logic prev;
  // synchronize the pin and keep one cycle of history for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= '0;
      prev <= 1'b0;
    end else begin
      meta <= {meta[0], din};
      prev <= meta[1];
    end
  assign lvl  = meta[1];
  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;
endmodule

// File: rtl/rz_decode.sv
// rz_decode: WS2812 RZ line decoder to 24-bit GRB words; RZ_DECODE_ERRCNT_EN builds the error counter
module rz_decode
  import rz_pkg::*;
#(
  parameter int T_MIN_HIGH = 8,
  parameter int T_THRESH   = 28,
  parameter int T_MAX_HIGH = 50,
  parameter int T_RESET    = RZ_T_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rz_in,
  output logic [23:0] rgb,
  output logic        rgb_valid,
  output logic        frame_end,
  output logic        bit_err,
  output logic [15:0] err_cnt
);
  localparam int CW = $clog2(T_RESET + 1);
  localparam logic [CW-1:0] C_MIN = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] C_TH  = CW'(T_THRESH);
  localparam logic [CW-1:0] C_MAX = CW'(T_MAX_HIGH);
  localparam logic [CW-1:0] C_RST = CW'(T_RESET);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  rz_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [4:0] bit_cnt, bit_cnt_n;
  logic [22:0] sr, sr_n;
  grb_t rgb_n;
  logic valid_n, fe_n, err_n, bit_v, lvl, rise, fall;
  rz_sync u_sync (.clk(clk), .rst(rst), .din(rz_in), .lvl(lvl), .rise(rise), .fall(fall));
  assign cnt_inc = cnt + C_ONE;
  assign bit_v   = cnt >= C_TH;
  // state, width counter, shift register and registered output pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= ST_SYNC;
      cnt       <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      rgb       <= '0;
      rgb_valid <= 1'b0;
      frame_end <= 1'b0;
      bit_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      sr        <= sr_n;
      rgb       <= rgb_n;
      rgb_valid <= valid_n;
      frame_end <= fe_n;
      bit_err   <= err_n;
    end
  // one counter measures whichever phase is current; it saturates at T_RESET so a gap fires once
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    rgb_n     = rgb;
    valid_n   = 1'b0;
    fe_n      = 1'b0;
    err_n     = 1'b0;
    case (state)
      ST_SYNC:
        if (lvl) cnt_n = '0;
        else if (cnt_inc == C_RST) begin
          state_n   = ST_LOW;
          cnt_n     = C_RST;
          bit_cnt_n = '0;
          sr_n      = '0;
        end else cnt_n = cnt_inc;
      ST_LOW:
        if (rise) begin
          state_n = ST_HIGH;
          cnt_n   = C_ONE;
        end else if (cnt != C_RST) begin
          cnt_n = cnt_inc;
          if (cnt_inc == C_RST) begin
            fe_n      = 1'b1;
            err_n     = bit_cnt != 5'd0;
            bit_cnt_n = '0;
            sr_n      = '0;
          end
        end
      ST_HIGH:
        if (fall) begin
          cnt_n = C_ONE;
          if (cnt < C_MIN) begin
            err_n   = 1'b1;
            state_n = ST_SYNC;
          end else begin
            state_n = ST_LOW;
            if (bit_cnt == 5'd23) begin
              rgb_n     = {sr, bit_v};
              valid_n   = 1'b1;
              bit_cnt_n = '0;
            end else begin
              sr_n      = {sr[21:0], bit_v};
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end else if (cnt == C_MAX) begin
          err_n   = 1'b1;
          state_n = ST_SYNC;
          cnt_n   = '0;
        end else cnt_n = cnt_inc;
      default: state_n = ST_SYNC;
    endcase
  end
`ifdef RZ_DECODE_ERRCNT_EN
  // saturating count of framing violations
  always_ff @(posedge clk or posedge rst)
    if (rst) err_cnt <= '0;
    else if (bit_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_rz_decode.sv
// tb_rz_decode: randomized and directed pulse-width stimulus against a pulse-level reference model
module tb_rz_decode;
  import rz_pkg::*;
  localparam int TMIN = 8;
  localparam int TTH  = 28;
  localparam int TMAX = 50;
  localparam int TRST = 2500;
  localparam logic [31:0] EV_FE  = 32'h0200_0000;
  localparam logic [31:0] EV_ERR = 32'h0300_0000;
  localparam logic [31:0] EV_FEE = 32'h0400_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rz_in = 1'b0;
  logic [23:0] rgb;
  logic rgb_valid, frame_end, bit_err;
  logic [15:0] err_cnt;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int valid_cyc = 0;
  int err_cyc = 0;
  int last_fall = 0;
  int rise_cyc = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  bit armed = 1'b0;
  int nbits = 0;
  int run = 0;
  int n_err = 0;
  logic [23:0] acc = '0;
  logic [23:0] last_word = '0;

  rz_decode dut (.clk(clk), .rst(rst), .rz_in(rz_in), .rgb(rgb), .rgb_valid(rgb_valid),
                 .frame_end(frame_end), .bit_err(bit_err), .err_cnt(err_cnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      if (rgb_valid) begin
        got_q.push_back({8'h01, rgb});
        valid_cyc = cyc;
      end
      if (frame_end && bit_err) got_q.push_back(EV_FEE);
      else if (frame_end) got_q.push_back(EV_FE);
      else if (bit_err) got_q.push_back(EV_ERR);
      if (bit_err) err_cyc = cyc;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rz_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic high(input int h);
    rise_cyc = cyc;
    drive(1'b1, h);
    last_fall = cyc;
    run = 0;
    if (armed) begin
      if (h < TMIN || h > TMAX) begin
        exp_q.push_back(EV_ERR);
        n_err++;
        armed = 1'b0;
      end else begin
        acc = {acc[22:0], h >= TTH};
        nbits++;
        if (nbits == 24) begin
          exp_q.push_back({8'h01, acc});
          last_word = acc;
          nbits = 0;
        end
      end
    end
  endtask

  task automatic low(input int l);
    int prior;
    drive(1'b0, l);
    prior = run;
    run += l;
    if (prior < TRST && run >= TRST) begin
      if (!armed) begin
        armed = 1'b1;
        nbits = 0;
      end else begin
        exp_q.push_back(nbits != 0 ? EV_FEE : EV_FE);
        if (nbits != 0) n_err++;
        nbits = 0;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    high(b ? RZ_T1H : RZ_T0H);
    low(b ? RZ_T1L : RZ_T0L);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset();
    rz_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", {8'h0, rgb}, 32'h0);
    chk("rst_valid", {31'h0, rgb_valid}, 32'h0);
    chk("rst_frame_end", {31'h0, frame_end}, 32'h0);
    chk("rst_bit_err", {31'h0, bit_err}, 32'h0);
    chk("rst_err_cnt", {16'h0, err_cnt}, 32'h0);
    rst = 1'b0;
    armed = 1'b0;
    nbits = 0;
    run = 0;
    n_err = 0;
    acc = '0;
    last_word = '0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic settle_check(input string tag);
    repeat (8) @(posedge clk);
    #1;
    chk({tag, "_nevents"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
`ifdef RZ_DECODE_ERRCNT_EN
    chk({tag, "_err_cnt"}, {16'h0, err_cnt}, n_err);
`else
    chk({tag, "_err_cnt"}, {16'h0, err_cnt}, 32'h0);
`endif
    chk({tag, "_rgb"}, {8'h0, rgb}, {8'h0, last_word});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int f;
    int h;
    int l;
    logic [7:0] r, g, b;
    @(posedge clk);
    #1;
    do_reset();
    // one word after a clean gap, with pin-to-valid latency
    low(2600);
    send_word(24'hA5C3F0);
    f = last_fall;
    low(2600);
    settle_check("word_a5c3f0");
    chk("valid_latency", valid_cyc - f, 3);
    chk("rgb_a5c3f0", {8'h0, rgb}, 32'h00A5C3F0);
    // bits before any gap are ignored, the next word after a gap decodes
    do_reset();
    send_word(24'h123456);
    low(2600);
    send_word(24'h0F1E2D);
    low(2600);
    settle_check("no_gap_then_word");
    // partial word then gap
    send_rand_bits(12);
    low(2600);
    settle_check("partial_gap");
    // glitch mid-word, then overflow with its timing, then recovery
    send_rand_bits(10);
    high(5);
    low(30);
    send_rand_bits(5);
    low(2600);
    send_rand_bits(3);
    high(60);
    chk("ovf_latency", err_cyc - rise_cyc, 53);
    low(2600);
    send_word(24'h5A5A5A);
    low(2600);
    settle_check("glitch_ovf");
    // back-to-back words
    send_word(24'h000000);
    send_word(24'hFFFFFF);
    low(2600);
    settle_check("back_to_back");
    // encoder-style 3-pixel frame
    for (int p = 0; p < 3; p++) begin
      r = 8'($urandom);
      g = 8'($urandom);
      b = 8'($urandom);
      send_word(grb_pack(r, g, b));
    end
    low(2600);
    settle_check("three_pixels");
    // gap boundaries: 2499 is not a gap, 2500 is
    send_rand_bits(5);
    high(20);
    low(2499);
    send_rand_bits(18);
    send_rand_bits(3);
    high(40);
    low(2500);
    send_word(24'hC0FFEE);
    low(2600);
    settle_check("gap_boundary");
    // high-width boundaries
    high(8);  low(20);
    high(27); low(20);
    high(28); low(20);
    high(50); low(20);
    high(7);  low(2600);
    high(51); low(2600);
    settle_check("width_boundary");
    // randomized pulse trains
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < int'($urandom_range(10, 30)); i++) begin
        h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 60)) : int'($urandom_range(8, 50));
        high(h);
        l = ($urandom_range(0, 19) == 0) ? int'($urandom_range(2495, 2505)) : int'($urandom_range(1, 60));
        low(l);
      end
      low(2600);
      settle_check("random");
    end
    // reset mid-word discards and requires a new gap
    send_rand_bits(7);
    do_reset();
    send_rand_bits(4);
    low(2600);
    send_word(24'h3C3C3C);
    low(2600);
    settle_check("reset_mid_word");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
